// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// mem_arb_pkg: shared types for the fetch/data memory port arbiter.  Rev 1.0
package mem_arb_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_BE_W   = ARB_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_id_t;

   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic [ARB_BE_W-1:0]   byteenable;
      port_id_t              port;
   } req_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// mem_port_arbiter_if: CPU fetch/data handshakes plus the memory-side bus.  Rev 1.0
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;
   logic [DATA_W-1:0]     i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_byteenable;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_W-1:0]     d_rdata;

   logic [ADDR_W-1:0]     mem_a;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_wd;
   logic [DATA_W/8-1:0]   mem_byteenable;
   logic [DATA_W-1:0]     mem_rd;

   logic                  busy;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_byteenable, mem_rd,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_a, mem_we, mem_wd, mem_byteenable, busy
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_byteenable, mem_rd,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_a, mem_we, mem_wd, mem_byteenable, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// rr_arb2: two-input arbiter, fixed data priority or round-robin on ties.  Rev 1.0
module rr_arb2
   import mem_arb_pkg::*;
#(
   parameter int DATA_PRIORITY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic ifetch_req_i,
   input  logic data_req_i,
   output logic ifetch_gnt_o,
   output logic data_gnt_o
);

   port_id_t last_grant_q;
   logic     data_wins_w;

   // On a tie the port that did not win last time goes first unless data is fixed-priority.
   always_comb begin
      data_wins_w  = data_req_i &&
                     (!ifetch_req_i || (DATA_PRIORITY != 0) || (last_grant_q == PORT_I));
      data_gnt_o   = en_i && data_wins_w;
      ifetch_gnt_o = en_i && ifetch_req_i && !data_wins_w;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= PORT_D;
      end else if (data_gnt_o) begin
         last_grant_q <= PORT_D;
      end else if (ifetch_gnt_o) begin
         last_grant_q <= PORT_I;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one registered-read memory between fetch and data ports.  Rev 1.0
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int DATA_PRIORITY = 1
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t state_q;
   req_t       req_q;
   req_t       req_d;
   logic       i_rvalid_q;
   logic       d_rvalid_q;
   logic       i_gnt_w;
   logic       d_gnt_w;
   logic       window_w;
   logic       in_access_w;

   assign window_w    = (state_q != ACCESS);
   assign in_access_w = (state_q == ACCESS);

   rr_arb2 #(
      .DATA_PRIORITY (DATA_PRIORITY)
   ) u_rr_arb2 (
      .clk          (clk),
      .reset        (reset),
      .en_i         (window_w),
      .ifetch_req_i (bus.i_req),
      .data_req_i   (bus.d_req),
      .ifetch_gnt_o (i_gnt_w),
      .data_gnt_o   (d_gnt_w)
   );

   // Fetches keep the previous write data so mem_wd holds its last value.
   always_comb begin
      req_d = req_q;
      if (d_gnt_w) begin
         req_d.we         = bus.d_we;
         req_d.addr       = ARB_ADDR_W'(bus.d_addr);
         req_d.wdata      = ARB_DATA_W'(bus.d_wdata);
         req_d.byteenable = ARB_BE_W'(bus.d_byteenable);
         req_d.port       = PORT_D;
      end else if (i_gnt_w) begin
         req_d.we         = 1'b0;
         req_d.addr       = ARB_ADDR_W'(bus.i_addr);
         req_d.byteenable = '1;
         req_d.port       = PORT_I;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         req_q      <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
      end else begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (i_gnt_w || d_gnt_w) begin
                  req_q   <= req_d;
                  state_q <= ACCESS;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               state_q    <= RESP;
               i_rvalid_q <= (req_q.port == PORT_I);
               d_rvalid_q <= (req_q.port == PORT_D);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.i_gnt    = i_gnt_w;
   assign bus.d_gnt    = d_gnt_w;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rvalid_q ? bus.mem_rd : '0;
   assign bus.d_rdata  = d_rvalid_q ? bus.mem_rd : '0;

   // Strobes decode straight from state so an async reset drops them at once.
   assign bus.mem_a          = ADDR_W'(req_q.addr);
   assign bus.mem_wd         = DATA_W'(req_q.wdata);
   assign bus.mem_we         = in_access_w & req_q.we;
   assign bus.mem_byteenable = in_access_w ? BE_W'(req_q.byteenable) : '0;
   assign bus.busy           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed checks with a small byte-lane memory model per instance.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_init = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1)) u_dut_a (
      .clk(clk), .reset(reset), .bus(ba));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0)) u_dut_b (
      .clk(clk), .reset(reset), .bus(bb));

   logic [31:0] mem_a_arr [0:15];
   logic [31:0] mem_b_arr [0:15];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 16; k++) mem_a_arr[k] <= 32'h0;
         mem_a_arr[0] <= 32'h12345678;
         mem_a_arr[1] <= 32'hA5A50001;
      end else if (ba.mem_we) begin
         for (int l = 0; l < 4; l++)
            if (ba.mem_byteenable[l]) mem_a_arr[ba.mem_a[5:2]][8*l +: 8] <= ba.mem_wd[8*l +: 8];
      end
      ba.mem_rd <= mem_a_arr[ba.mem_a[5:2]];
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 16; k++) mem_b_arr[k] <= 32'h0;
         mem_b_arr[0] <= 32'h0B0B0B0B;
         mem_b_arr[1] <= 32'h0D0D0D0D;
      end else if (bb.mem_we) begin
         for (int l = 0; l < 4; l++)
            if (bb.mem_byteenable[l]) mem_b_arr[bb.mem_a[5:2]][8*l +: 8] <= bb.mem_wd[8*l +: 8];
      end
      bb.mem_rd <= mem_b_arr[bb.mem_a[5:2]];
   end

   task automatic test_reset();
      #1;
      total++; if (ba.busy !== 1'b0) begin bad++; $display("FAIL reset_busy act=%h exp=0", ba.busy); end
      total++; if ({ba.i_gnt, ba.d_gnt, ba.i_rvalid, ba.d_rvalid} !== 4'b0000) begin bad++;
         $display("FAIL reset_handshake act=%b exp=0000", {ba.i_gnt, ba.d_gnt, ba.i_rvalid, ba.d_rvalid}); end
      total++; if (ba.mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a act=%h exp=0", ba.mem_a); end
      total++; if (ba.mem_wd !== 32'h0) begin bad++; $display("FAIL reset_mem_wd act=%h exp=0", ba.mem_wd); end
      total++; if ({ba.mem_we, ba.mem_byteenable} !== 5'b0) begin bad++;
         $display("FAIL reset_mem_strobes act=%b exp=00000", {ba.mem_we, ba.mem_byteenable}); end
   endtask

   task automatic test_single_fetch();
      ba.i_req = 1'b1; ba.i_addr = 32'hBFC00000;
      #1;
      total++; if ({ba.i_gnt, ba.d_gnt} !== 2'b10) begin bad++;
         $display("FAIL fetch_gnt act=%b exp=10", {ba.i_gnt, ba.d_gnt}); end
      @(negedge clk); ba.i_req = 1'b0; #1;
      total++; if (ba.mem_a !== 32'hBFC00000) begin bad++; $display("FAIL fetch_mem_a act=%h exp=bfc00000", ba.mem_a); end
      total++; if ({ba.busy, ba.mem_we, ba.i_gnt} !== 3'b100) begin bad++;
         $display("FAIL fetch_access act=%b exp=100", {ba.busy, ba.mem_we, ba.i_gnt}); end
      @(negedge clk); #1;
      total++; if ({ba.i_rvalid, ba.d_rvalid} !== 2'b10) begin bad++;
         $display("FAIL fetch_rvalid act=%b exp=10", {ba.i_rvalid, ba.d_rvalid}); end
      total++; if (ba.i_rdata !== 32'h12345678) begin bad++; $display("FAIL fetch_rdata act=%h exp=12345678", ba.i_rdata); end
      @(negedge clk); #1;
      total++; if ({ba.i_rvalid, ba.busy} !== 2'b00) begin bad++;
         $display("FAIL fetch_idle act=%b exp=00", {ba.i_rvalid, ba.busy}); end
   endtask

   task automatic test_back_to_back();
      ba.d_req = 1'b1; ba.d_we = 1'b1; ba.d_addr = 32'hBFC00010;
      ba.d_wdata = 32'hDEADBEEF; ba.d_byteenable = 4'hF;
      #1;
      total++; if ({ba.i_gnt, ba.d_gnt} !== 2'b01) begin bad++;
         $display("FAIL store_gnt act=%b exp=01", {ba.i_gnt, ba.d_gnt}); end
      @(negedge clk); ba.d_req = 1'b0; #1;
      total++; if ({ba.mem_we, ba.mem_byteenable} !== 5'b11111) begin bad++;
         $display("FAIL store_strobes act=%b exp=11111", {ba.mem_we, ba.mem_byteenable}); end
      total++; if ({ba.mem_a, ba.mem_wd} !== {32'hBFC00010, 32'hDEADBEEF}) begin bad++;
         $display("FAIL store_addr_data act=%h/%h exp=bfc00010/deadbeef", ba.mem_a, ba.mem_wd); end
      @(negedge clk); #1;
      total++; if ({ba.mem_we, ba.d_rvalid, ba.i_rvalid} !== 3'b010) begin bad++;
         $display("FAIL store_ack act=%b exp=010", {ba.mem_we, ba.d_rvalid, ba.i_rvalid}); end
      ba.d_req = 1'b1; ba.d_we = 1'b0; #1;
      total++; if (ba.d_gnt !== 1'b1) begin bad++; $display("FAIL load_gnt_in_resp act=%b exp=1", ba.d_gnt); end
      @(negedge clk); ba.d_req = 1'b0; #1;
      total++; if ({ba.d_rvalid, ba.mem_we} !== 2'b00) begin bad++;
         $display("FAIL load_access act=%b exp=00", {ba.d_rvalid, ba.mem_we}); end
      @(negedge clk); #1;
      total++; if (ba.d_rvalid !== 1'b1) begin bad++; $display("FAIL load_rvalid act=%b exp=1", ba.d_rvalid); end
      total++; if (ba.d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata act=%h exp=deadbeef", ba.d_rdata); end
      @(negedge clk);
   endtask

   task automatic test_tie_data_priority();
      ba.i_req = 1'b1; ba.i_addr = 32'hBFC00000;
      ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 32'hBFC00004; ba.d_byteenable = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if ({ba.i_gnt, ba.d_gnt} !== 2'b01) begin bad++;
            $display("FAIL tie1_gnt%0d act=%b exp=01", k, {ba.i_gnt, ba.d_gnt}); end
         @(negedge clk); #1;
         total++; if ({ba.i_gnt, ba.d_gnt} !== 2'b00) begin bad++;
            $display("FAIL tie1_access_gnt%0d act=%b exp=00", k, {ba.i_gnt, ba.d_gnt}); end
         @(negedge clk); #1;
         total++; if ({ba.i_rvalid, ba.d_rvalid, ba.d_rdata} !== {2'b01, 32'hA5A50001}) begin bad++;
            $display("FAIL tie1_resp%0d act=%b/%h exp=01/a5a50001", k, {ba.i_rvalid, ba.d_rvalid}, ba.d_rdata); end
      end
      ba.d_req = 1'b0; #1;
      total++; if ({ba.i_gnt, ba.d_gnt} !== 2'b10) begin bad++;
         $display("FAIL tie1_fetch_after_drop act=%b exp=10", {ba.i_gnt, ba.d_gnt}); end
      @(negedge clk); ba.i_req = 1'b0;
      @(negedge clk); #1;
      total++; if ({ba.i_rvalid, ba.i_rdata} !== {1'b1, 32'h12345678}) begin bad++;
         $display("FAIL tie1_fetch_resp act=%b/%h exp=1/12345678", ba.i_rvalid, ba.i_rdata); end
      @(negedge clk);
   endtask

   task automatic test_tie_round_robin();
      logic prev_d;
      logic exp_d;
      bb.i_req = 1'b1; bb.i_addr = 32'hBFC00000;
      bb.d_req = 1'b0; bb.d_we = 1'b0; bb.d_addr = 32'hBFC00004; bb.d_byteenable = 4'hF;
      #1;
      total++; if ({bb.i_gnt, bb.d_gnt} !== 2'b10) begin bad++;
         $display("FAIL rr_lone_fetch_gnt act=%b exp=10", {bb.i_gnt, bb.d_gnt}); end
      @(negedge clk); bb.d_req = 1'b1;
      prev_d = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         exp_d = (k % 2 == 0);
         total++; if ({bb.d_rvalid, bb.i_rvalid} !== {prev_d, ~prev_d}) begin bad++;
            $display("FAIL rr_rvalid%0d act=%b exp=%b", k, {bb.d_rvalid, bb.i_rvalid}, {prev_d, ~prev_d}); end
         total++; if ((prev_d ? bb.d_rdata : bb.i_rdata) !== (prev_d ? 32'h0D0D0D0D : 32'h0B0B0B0B)) begin bad++;
            $display("FAIL rr_rdata%0d act=%h/%h", k, bb.d_rdata, bb.i_rdata); end
         total++; if ({bb.d_gnt, bb.i_gnt} !== {exp_d, ~exp_d}) begin bad++;
            $display("FAIL rr_gnt%0d act=%b exp=%b", k, {bb.d_gnt, bb.i_gnt}, {exp_d, ~exp_d}); end
         prev_d = exp_d;
         @(negedge clk);
         if (k == 3) begin bb.i_req = 1'b0; bb.d_req = 1'b0; end
      end
      @(negedge clk); #1;
      total++; if ({bb.d_rvalid, bb.i_rvalid, bb.i_rdata} !== {2'b01, 32'h0B0B0B0B}) begin bad++;
         $display("FAIL rr_last_resp act=%b/%h exp=01/0b0b0b0b", {bb.d_rvalid, bb.i_rvalid}, bb.i_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_in_access();
      ba.d_req = 1'b1; ba.d_we = 1'b1; ba.d_addr = 32'hBFC00010;
      ba.d_wdata = 32'hCAFEF00D; ba.d_byteenable = 4'hF;
      #1;
      total++; if (ba.d_gnt !== 1'b1) begin bad++; $display("FAIL rst_store_gnt act=%b exp=1", ba.d_gnt); end
      @(negedge clk); ba.d_req = 1'b0; #1;
      total++; if (ba.mem_we !== 1'b1) begin bad++; $display("FAIL rst_pre_we act=%b exp=1", ba.mem_we); end
      #1 reset = 1'b1; #1;
      total++; if ({ba.mem_we, ba.busy, ba.mem_byteenable} !== 6'b0) begin bad++;
         $display("FAIL rst_async_strobes act=%b exp=000000", {ba.mem_we, ba.busy, ba.mem_byteenable}); end
      total++; if ({ba.mem_a, ba.mem_wd} !== 64'h0) begin bad++;
         $display("FAIL rst_async_bus act=%h/%h exp=0/0", ba.mem_a, ba.mem_wd); end
      @(negedge clk); reset = 1'b0; #1;
      total++; if ({ba.d_rvalid, ba.busy} !== 2'b00) begin bad++;
         $display("FAIL rst_no_rvalid act=%b exp=00", {ba.d_rvalid, ba.busy}); end
      @(negedge clk); #1;
      total++; if (ba.d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_no_rvalid_late act=%b exp=0", ba.d_rvalid); end
      ba.d_req = 1'b1; ba.d_we = 1'b0;
      @(negedge clk); ba.d_req = 1'b0;
      @(negedge clk); #1;
      total++; if ({ba.d_rvalid, ba.d_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
         $display("FAIL rst_store_dropped act=%b/%h exp=1/deadbeef", ba.d_rvalid, ba.d_rdata); end
      @(negedge clk);
   endtask

   task automatic test_mask_zero();
      ba.d_req = 1'b1; ba.d_we = 1'b1; ba.d_addr = 32'hBFC00010;
      ba.d_wdata = 32'h11111111; ba.d_byteenable = 4'h0;
      @(negedge clk); ba.d_req = 1'b0; #1;
      total++; if ({ba.mem_we, ba.mem_byteenable} !== 5'b10000) begin bad++;
         $display("FAIL mask0_strobes act=%b exp=10000", {ba.mem_we, ba.mem_byteenable}); end
      @(negedge clk); #1;
      total++; if (ba.d_rvalid !== 1'b1) begin bad++; $display("FAIL mask0_ack act=%b exp=1", ba.d_rvalid); end
      ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_byteenable = 4'hF;
      @(negedge clk); ba.d_req = 1'b0;
      @(negedge clk); #1;
      total++; if ({ba.d_rvalid, ba.d_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
         $display("FAIL mask0_readback act=%b/%h exp=1/deadbeef", ba.d_rvalid, ba.d_rdata); end
      @(negedge clk);
   endtask

   initial begin
      ba.i_req = 1'b0; ba.i_addr = '0; ba.d_req = 1'b0; ba.d_we = 1'b0;
      ba.d_addr = '0; ba.d_wdata = '0; ba.d_byteenable = '0;
      bb.i_req = 1'b0; bb.i_addr = '0; bb.d_req = 1'b0; bb.d_we = 1'b0;
      bb.d_addr = '0; bb.d_wdata = '0; bb.d_byteenable = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0; mem_init = 1'b0;
      test_reset();
      @(negedge clk);
      test_single_fetch();
      test_back_to_back();
      test_tie_data_priority();
      test_tie_round_robin();
      test_reset_in_access();
      test_mask_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
